// File: rtl/instr_stim_gen_pkg.sv
// instr_stim_gen_pkg
//   Shared types and helpers for the pseudo-random instruction stream
//   generator: RV32 opcode and FSM state enums, the LFSR feedback mask,
//   opcode selection with enable-mask fallback, and per-format encoders.
package instr_stim_gen_pkg;

  typedef enum logic [6:0] {
    OPCODE_I_TYPE = 7'b0010011,
    OPCODE_R_TYPE = 7'b0110011,
    OPCODE_B_TYPE = 7'b1100011,
    OPCODE_J_TYPE = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index into the opcode enable mask and the counter array.
  typedef enum logic [1:0] {
    SEL_ADDI = 2'd0,
    SEL_ADD  = 2'd1,
    SEL_BEQ  = 2'd2,
    SEL_JAL  = 2'd3
  } sel_e;

  // x^32 + x^22 + x^2 + x + 1, Galois right-shift form.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // Raw selector from the LFSR; a disabled opcode falls through to the next
  // enabled one in increasing order, wrapping 3 -> 0. The mask is nonzero,
  // so the loop always finds something.
  function automatic logic [1:0] pick_sel(input logic [1:0] sel,
                                          input logic [3:0] mask);
    logic [1:0] s;
    logic       found;
    pick_sel = sel;
    found    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = sel + 2'(k);
      if (!found && mask[s]) begin
        pick_sel = s;
        found    = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm,
                                        input logic [4:0]  rs1,
                                        input logic [4:0]  rd);
    enc_i = {imm, rs1, 3'b000, rd, OPCODE_I_TYPE};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rd);
    enc_r = {7'b0000000, rs2, rs1, 3'b000, rd, OPCODE_R_TYPE};
  endfunction

  // off holds byte offset bits [12:1]; bit 0 is always zero.
  function automatic logic [31:0] enc_b(input logic [12:1] off,
                                        input logic [4:0]  rs2,
                                        input logic [4:0]  rs1);
    enc_b = {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11],
             OPCODE_B_TYPE};
  endfunction

  // off holds byte offset bits [20:1]; bit 0 is always zero.
  function automatic logic [31:0] enc_j(input logic [20:1] off,
                                        input logic [4:0]  rd);
    enc_j = {off[20], off[10:1], off[11], off[19:12], rd, OPCODE_J_TYPE};
  endfunction

endpackage

// File: rtl/instr_stim_gen_lfsr32.sv
// lfsr32
//   32-bit Galois right-shift LFSR with synchronous load of a seed.
//   A zero seed would lock the register, so it is replaced by 1.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset (state -> seed)
//   load        : reload seed (wins over step)
//   step        : advance one state
//   q           : current state
module lfsr32
  import instr_stim_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        load,
  input  logic        step,
  output logic [31:0] q
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] nxt;
  assign nxt = (q >> 1) ^ (q[0] ? LFSR_MASK : 32'd0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)   q <= SEED_EFF;
    else if (load) q <= SEED_EFF;
    else if (step) q <= nxt;
  end

endmodule

// File: rtl/instr_stim_gen.sv
// instr_stim_gen
//   Pseudo-random RV32 ADDI/ADD/BEQ/JAL stream for core self-test. Fields
//   and opcode choice come straight from the registered LFSR, so the
//   presented instruction is stable while the consumer stalls. One
//   instruction per accepted handshake, NUM_INSTR per run, with saturating
//   per-opcode issue counters for comparison against retire statistics.
// Ports:
//   clk, arst_n        : clock, asynchronous active-low reset
//   start              : begin a run from IDLE or DONE
//   abort              : drop back to IDLE (beats start; a same-cycle
//                        accept is still counted)
//   safe_br            : branch/jump offsets limited to 4..16, latched at start
//   instr_valid/ready  : handshake; instruction is 0 when not valid
//   busy, done         : state == RUN, state == DONE
//   cnt_addi..cnt_jal  : instructions issued per opcode
module instr_stim_gen
  import instr_stim_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          DIR_WIDTH  = 5,
  parameter int          NUM_INSTR  = 100,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001,
  parameter logic [3:0]  EN_MASK    = 4'b1111
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  safe_br,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  cnt_addi,
  output logic [CNT_WIDTH-1:0]  cnt_add,
  output logic [CNT_WIDTH-1:0]  cnt_beq,
  output logic [CNT_WIDTH-1:0]  cnt_jal
);

  localparam int IW = (NUM_INSTR < 2) ? 1 : $clog2(NUM_INSTR);
  localparam logic [IW-1:0] LAST = IW'(NUM_INSTR - 1);

  state_e                         state_q, state_d;
  logic                           load, accept, safe_q;
  logic [31:0]                    lfsr;
  logic [IW-1:0]                  issued_q;
  logic [3:0][CNT_WIDTH-1:0]      cnt_q;
  logic [1:0]                     sel;

  // ---------------------------------------------------------------- LFSR
  lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .arst_n (arst_n),
    .load   (load),
    .step   (accept),
    .q      (lfsr)
  );

  // ----------------------------------------------------------------- FSM
  assign accept = (state_q == ST_RUN) && instr_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort)                           state_d = ST_IDLE;
        else if (accept && issued_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (abort) state_d = ST_IDLE;
        else if (start) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------ run bookkeeping
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      issued_q <= '0;
      safe_q   <= 1'b0;
    end else if (load) begin
      issued_q <= '0;
      safe_q   <= safe_br;
    end else if (accept && issued_q != LAST) begin
      issued_q <= issued_q + 1'b1;
    end
  end

  // One saturating counter per opcode, indexed by the selector.
  for (genvar g = 0; g < 4; g++) begin : g_cnt
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)                  cnt_q[g] <= '0;
      else if (load)                cnt_q[g] <= '0;
      else if (accept && sel == 2'(g) && cnt_q[g] != '1)
                                    cnt_q[g] <= cnt_q[g] + 1'b1;
    end
  end

  assign cnt_addi = cnt_q[SEL_ADDI];
  assign cnt_add  = cnt_q[SEL_ADD];
  assign cnt_beq  = cnt_q[SEL_BEQ];
  assign cnt_jal  = cnt_q[SEL_JAL];

  // -------------------------------------------------------------- encoder
  logic [DIR_WIDTH-1:0] rd, rs1, rs2;
  logic [11:0]          imm12;
  logic [2:0]           safe_off;   // offset / 4, i.e. 1..4
  logic [12:1]          b_off;
  logic [20:1]          j_off;
  logic [31:0]          enc;

  assign sel      = pick_sel(lfsr[1:0], EN_MASK);
  assign rd       = lfsr[6:2];
  assign rs1      = lfsr[11:7];
  assign rs2      = lfsr[16:12];
  assign imm12    = lfsr[28:17];
  assign safe_off = {1'b0, lfsr[3:2]} + 3'd1;
  assign b_off    = safe_q ? {8'd0,  safe_off, 1'b0} : lfsr[29:18];
  assign j_off    = safe_q ? {16'd0, safe_off, 1'b0} : lfsr[31:12];

  always_comb begin
    enc = '0;
    case (sel)
      SEL_ADDI: enc = enc_i(imm12, rs1, rd);
      SEL_ADD:  enc = enc_r(rs2, rs1, rd);
      SEL_BEQ:  enc = enc_b(b_off, rs2, rs1);
      default:  enc = enc_j(j_off, rd);
    endcase
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign instr_valid = busy;
  assign instruction = busy ? DATA_WIDTH'(enc) : '0;

endmodule

// File: tb/tb_instr_stim_gen.sv
// tb_instr_stim_gen
//   Directed bench: two generator instances (all opcodes, ADDI-only),
//   hand-computed encodings for the first instructions from seed 1,
//   stall stability, full run with done timing, abort/restart, async
//   reset mid-run, and branch-safe mode under random ready.
module tb_instr_stim_gen;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, safe_br = 1'b0, ready = 1'b0;
  logic        valid, busy, done;
  logic [31:0] instruction;
  logic [15:0] c_addi, c_add, c_beq, c_jal;

  logic        start_b = 1'b0, ready_b = 1'b0;
  logic        valid_b, busy_b, done_b;
  logic [31:0] instr_b;
  logic [15:0] b_addi, b_add, b_beq, b_jal;

  int n_tests = 0, n_fail = 0;
  logic [31:0] seq [0:99];
  int t_addi, t_add, t_beq, t_jal;

  always #5 clk = ~clk;

  instr_stim_gen u_dut (
    .clk(clk), .arst_n(arst_n), .start(start), .abort(abort), .safe_br(safe_br),
    .instr_valid(valid), .instr_ready(ready), .instruction(instruction),
    .busy(busy), .done(done),
    .cnt_addi(c_addi), .cnt_add(c_add), .cnt_beq(c_beq), .cnt_jal(c_jal)
  );

  instr_stim_gen #(.EN_MASK(4'b0001)) u_dut_b (
    .clk(clk), .arst_n(arst_n), .start(start_b), .abort(1'b0), .safe_br(1'b0),
    .instr_valid(valid_b), .instr_ready(ready_b), .instruction(instr_b),
    .busy(busy_b), .done(done_b),
    .cnt_addi(b_addi), .cnt_add(b_add), .cnt_beq(b_beq), .cnt_jal(b_jal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_tally();
    t_addi = 0; t_add = 0; t_beq = 0; t_jal = 0;
  endtask

  task automatic tally(input logic [31:0] i);
    case (i[6:0])
      7'b0010011: t_addi++;
      7'b0110011: t_add++;
      7'b1100011: t_beq++;
      7'b1101111: t_jal++;
      default: chk("opcode_legal", {25'd0, i[6:0]}, 32'h13);
    endcase
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_addi"}, 32'(c_addi), 32'(t_addi));
    chk({tag, "_add"},  32'(c_add),  32'(t_add));
    chk({tag, "_beq"},  32'(c_beq),  32'(t_beq));
    chk({tag, "_jal"},  32'(c_jal),  32'(t_jal));
  endtask

  function automatic logic [31:0] boff(input logic [31:0] i);
    boff = {19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] joff(input logic [31:0] i);
    joff = {11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  initial begin
    logic [31:0] ins, off;
    int acc, cyc;

    // ---- reset state
    tick(); tick();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_instr", instruction, 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_cnts",  32'(c_addi) + 32'(c_add) + 32'(c_beq) + 32'(c_jal), 0);
    arst_n = 1'b1;
    tick();

    // ---- start, first instruction one cycle later, stall for 5 cycles
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy",  32'(busy), 1);
    chk("start_valid", 32'(valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_instr", instruction, 32'h0000_0033);
      chk("stall_valid", 32'(valid), 1);
      chk("stall_cnt",   32'(c_add), 0);
      tick();
    end

    // ---- full default run, ready=1
    ready = 1'b1;
    clr_tally();
    for (int i = 0; i < 100; i++) begin
      seq[i] = instruction;
      if (i == 0) chk("first_add",  instruction, 32'h0000_0033);
      if (i == 1) chk("second_jal", instruction, 32'hC000_006F);
      if (i == 2) chk("third_beq",  instruction, 32'h0000_0C63);
      chk("run_done_low", 32'(done), 0);
      tally(instruction);
      tick();
    end
    chk("run_done",      32'(done), 1);
    chk("run_valid_off", 32'(valid), 0);
    chk("run_instr_off", instruction, 0);
    chk("run_busy_off",  32'(busy), 0);
    chk_cnts("run_cnt");
    chk("run_sum", 32'(c_addi) + 32'(c_add) + 32'(c_beq) + 32'(c_jal), 100);
    tick();
    chk("done_hold", 32'(done), 1);

    // ---- restart, abort after 37 accepts
    start = 1'b1; tick(); start = 1'b0;
    clr_tally();
    for (int i = 0; i < 37; i++) begin
      chk("abort_seq", instruction, seq[i]);
      tally(instruction);
      tick();
    end
    ready = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy",  32'(busy), 0);
    chk("abort_done",  32'(done), 0);
    chk("abort_valid", 32'(valid), 0);
    chk_cnts("abort_cnt");
    chk("abort_sum", 32'(c_addi) + 32'(c_add) + 32'(c_beq) + 32'(c_jal), 37);

    // ---- restart reproduces sequence; async reset mid-run
    ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("restart_seq", instruction, seq[i]);
      tick();
    end
    #2 arst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 0);
    chk("arst_instr", instruction, 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_cnts",  32'(c_addi) + 32'(c_add) + 32'(c_beq) + 32'(c_jal), 0);
    tick();
    arst_n = 1'b1;
    tick();

    // ---- branch-safe mode, random ready
    safe_br = 1'b1;
    start = 1'b1; tick(); start = 1'b0; safe_br = 1'b0;
    clr_tally();
    acc = 0; cyc = 0;
    while (acc < 100 && cyc < 3000) begin
      ready = 1'($urandom_range(0, 1));
      if (valid && ready) begin
        ins = instruction;
        if (acc == 0) chk("safe_first",  ins, 32'h0000_0033);
        if (acc == 1) chk("safe_jal",    ins, 32'h0040_006F);
        if (acc == 2) chk("safe_beq",    ins, 32'h0000_0263);
        if (ins[6:0] == 7'b1100011 || ins[6:0] == 7'b1101111) begin
          off = (ins[6:0] == 7'b1100011) ? boff(ins) : joff(ins);
          chk("safe_off_ok",
              32'(off == 4 || off == 8 || off == 12 || off == 16), 1);
        end else begin
          chk("safe_nonbr_seq", ins, seq[acc]);
        end
        tally(ins);
        acc++;
      end
      tick();
      cyc++;
    end
    ready = 1'b0;
    chk("safe_acc_bound", 32'(acc), 100);
    chk("safe_done", 32'(done), 1);
    chk_cnts("safe_cnt");
    chk("safe_sum", 32'(c_addi) + 32'(c_add) + 32'(c_beq) + 32'(c_jal), 100);

    // ---- ADDI-only instance
    start_b = 1'b1; tick(); start_b = 1'b0;
    ready_b = 1'b1;
    chk("mask_first", instr_b, 32'h0000_0013);
    for (int i = 0; i < 100; i++) begin
      chk("mask_opcode", {25'd0, instr_b[6:0]}, 32'h13);
      chk("mask_done_low", 32'(done_b), 0);
      tick();
    end
    chk("mask_done", 32'(done_b), 1);
    chk("mask_addi", 32'(b_addi), 100);
    chk("mask_other", 32'(b_add) + 32'(b_beq) + 32'(b_jal), 0);
    chk("mask_busy", 32'(busy_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
